// File: rtl/esm_pkg.sv
// rtl/esm_pkg.sv - shared sizes and slot types for the ESM issue scheduler
package esm_pkg;
  localparam int unsigned bs_default = 16;
  localparam int unsigned iw_default = $clog2(bs_default);

  typedef logic [0:bs_default-1] slot_vec_t;
  typedef logic [iw_default-1:0] slot_idx_t;
endpackage

// File: rtl/esm_rr_picker.sv
// rtl/esm_rr_picker.sv - first set bit at or after start, wrapping modulo n
module esm_rr_picker #(
  parameter int n = 16,
  parameter int w = $clog2(n)
) (
  input  logic [0:n-1] req,
  input  logic [w-1:0] start,
  output logic         any,
  output logic [w-1:0] index
);

  logic [w-1:0] probe;

  // n is a power of two, so the index adder wraps naturally
  always_comb begin
    any   = 1'b0;
    index = '0;
    probe = '0;
    for (int k = 0; k < n; k++) begin
      probe = start + w'(k);
      if (!any && req[probe]) begin
        any   = 1'b1;
        index = probe;
      end
    end
  end

endmodule

// File: rtl/esm_issue_scheduler.sv
// rtl/esm_issue_scheduler.sv - slot allocation and round-robin issue for the ESM instruction buffer
module esm_issue_scheduler
  import esm_pkg::*;
#(
  parameter int bs = bs_default,
  parameter int IW = $clog2(bs)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          alloc_req,
  output logic          alloc_gnt,
  output logic [IW-1:0] alloc_index,
  output logic [0:bs-1] valid_entries,
  input  logic [0:bs-1] independent_instr,
  output logic          issue_valid,
  output logic [IW-1:0] issue_index,
  input  logic          issue_ready,
  input  logic          complete_valid,
  input  logic [IW-1:0] complete_index,
  input  logic          flush,
  output logic [IW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          err
);

  localparam logic [IW:0] full_count = (IW+1)'(bs);

  logic [0:bs-1] valid, issued, valid_n, issued_n, cand;
  logic [IW-1:0] rr_ptr, free_idx, sel;
  logic          free_any, cand_any, load, comp_ok;
  logic [IW:0]   count_n;

  esm_rr_picker #(.n(bs), .w(IW)) u_free_pick (
    .req   (~valid),
    .start ('0),
    .any   (free_any),
    .index (free_idx)
  );

  esm_rr_picker #(.n(bs), .w(IW)) u_issue_pick (
    .req   (cand),
    .start (rr_ptr),
    .any   (cand_any),
    .index (sel)
  );

  // valid is still clear for a slot being granted, so it cannot be a candidate yet
  assign cand          = valid & ~issued & independent_instr;
  assign alloc_gnt     = alloc_req & ~full & free_any & ~flush;
  assign alloc_index   = (alloc_req & ~full & free_any) ? free_idx : '0;
  assign valid_entries = valid;
  assign load          = ~issue_valid | issue_ready;

  // the slot still waiting in the issue register has not been handed over yet
  assign comp_ok = complete_valid & valid[complete_index] & issued[complete_index]
                 & ~(issue_valid & (issue_index == complete_index));

  always_comb begin
    valid_n  = valid;
    issued_n = issued;
    if (alloc_gnt) valid_n[alloc_index] = 1'b1;
    if (comp_ok) begin
      valid_n[complete_index]  = 1'b0;
      issued_n[complete_index] = 1'b0;
    end
    if (load && cand_any) issued_n[sel] = 1'b1;
    count_n = count + (IW+1)'(alloc_gnt) - (IW+1)'(comp_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid       <= '0;
      issued      <= '0;
      rr_ptr      <= '0;
      issue_valid <= 1'b0;
      issue_index <= '0;
      err         <= 1'b0;
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
    end else if (flush) begin
      valid       <= '0;
      issued      <= '0;
      rr_ptr      <= '0;
      issue_valid <= 1'b0;
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
    end else begin
      valid  <= valid_n;
      issued <= issued_n;
      count  <= count_n;
      full   <= (count_n == full_count);
      empty  <= (count_n == '0);
      if (complete_valid && !comp_ok) err <= 1'b1;
      if (load) begin
        issue_valid <= cand_any;
        if (cand_any) begin
          issue_index <= sel;
          rr_ptr      <= sel + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/esm_issue_scheduler.md
Name: esm_issue_scheduler

Overview:
Owns slot allocation and instruction issue for the ESM instruction buffer that feeds the IDA core (IRT/IDT).
- Hands the decoder a free buffer_index for each incoming instruction and drives the valid_entries vector.
- Takes the IDA independent_instr vector and issues one ready slot per cycle to execution, round-robin, through a valid/ready handshake.
- Frees slots on completion or flush.

Parameters:
bs, 16, instruction buffer slots; power of two, >= 2
IW, $clog2(bs), slot index width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
alloc_req  input  1  decoder has an instruction to insert
alloc_gnt  output  1  alloc_req & !full; slot alloc_index is taken this cycle
alloc_index  output  IW  lowest-numbered free slot; to IDA buffer_index; 0 when full
valid_entries  output  [0:bs-1]  slot occupancy (bit i = slot i), to IDA
independent_instr  input  [0:bs-1]  from IDA; slot has no outstanding dependence
issue_valid  output  1  issue_index holds an instruction for execution
issue_index  output  IW  slot being issued
issue_ready  input  1  execution accepts issue_index this cycle
complete_valid  input  1  execution finished slot complete_index
complete_index  input  IW  completed slot
flush  input  1  discard all buffered/issued instructions
count  output  IW+1  number of occupied slots
full  output  1  count == bs
empty  output  1  count == 0
err  output  1  sticky: completion for a slot not in issued state

Behaviour:
- Reset (async, rst=1): valid, issued, rr_ptr, issue_valid, issue_index, err, count = 0; empty = 1, full = 0. alloc_gnt and alloc_index are combinational: 0 while alloc_req=0.
- Per-slot state: valid[i], issued[i].
  - FREE = !valid.
  - WAITING = valid & !issued.
  - ISSUED = valid & issued.
  - Transitions:
    - FREE -> WAITING on alloc_gnt.
    - WAITING -> ISSUED when loaded into the issue register.
    - ISSUED -> FREE on a matching complete_valid.
    - Any -> FREE on flush.
- Allocation: alloc_index is the find-first-zero of valid. valid[alloc_index] is set at the next edge. A slot freed in cycle N is allocatable from N+1; there is no same-cycle bypass.
- Candidate vector: valid & !issued & independent_instr. Slots allocated this cycle are never candidates.
- Issue register: loads when !issue_valid | issue_ready.
  - If any candidate exists: issue_valid <= 1, issue_index <= the first candidate at index >= rr_ptr, wrapping modulo bs; issued[sel] <= 1; rr_ptr <= (sel+1) mod bs.
  - Otherwise issue_valid <= 0.
- Latency: one cycle from candidate to issue_valid. With issue_ready held at 1, one issue per cycle.
- Stall rule: while issue_valid & !issue_ready, issue_index and issue_valid are held stable and rr_ptr does not move.
- Completion: if complete_valid & valid[ci] & issued[ci], clear valid[ci] and issued[ci] at the next edge. Otherwise ignore it and set err (cleared only by rst).
  - Completion of the slot currently in the issue register before handshake is an error; state is unchanged.
- Simultaneous events in one cycle:
  - Alloc and complete: both apply; count = count + 1 - 1.
  - Issue-load and complete of different slots: both apply.
- flush: highest priority. Next edge: valid, issued = 0; issue_valid = 0; rr_ptr = 0; count = 0. alloc_gnt is forced 0 during flush. err is unaffected.
- count/full/empty are registered, updated the same edge as valid. count never exceeds bs or goes below 0.
- Dependence clearing on completion is owned by the IDA; this block only consumes independent_instr.

Decomposition:
- Package esm_pkg:
  - bs default and IW constant.
  - slot_vec_t ([0:bs-1] logic).
  - slot_idx_t ([IW-1:0]).
- Sub-module esm_rr_picker: combinational. Inputs: req vector, start pointer. Outputs: any, index of first set bit at or after the pointer, with wrap. It is reused for find-first-zero with pointer 0 on ~valid.

Test Plan:
1. Reset then 16 alloc_req pulses (bs=16) -> alloc_index 0..15 in order; full=1, count=16; 17th request gives alloc_gnt=0.
2. Slots 0,1,2 valid, independent_instr=all 1, issue_ready=1 -> issue_index 0,1,2 on consecutive cycles, then issue_valid=0.
3. issue_ready=0 for 3 cycles with slot 5 in the issue register -> issue_index=5 held stable; after ready, the next issue is the first candidate >5 (wrapping to 0 if none).
4. Slots 3 and 9 independent, rr_ptr=4 -> slot 9 issued before slot 3; slot 3 issued next.
5. complete_index=2 in the same cycle as alloc_req with full=1 -> alloc_gnt=0 that cycle; next cycle alloc_index=2, count stays 16 after re-alloc.
6. Completion on a WAITING slot -> err=1 and slot state unchanged. flush mid-issue -> next cycle issue_valid=0, valid_entries=0, empty=1, err still 1.
